// File: rtl/gf256_poly_div_iterative.sv
// GF(2^8) divider: poly_out = poly_a * poly_b^254, computed by iterative square-and-multiply.
// Define GF256_DIV_FASTPATH_EN to finish divisors 0 and 1 directly at accept (latency 1).
module gf256_poly_div_iterative #(
    parameter logic [7:0] POLY = 8'h1D,
    parameter int         ITER = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] poly_a,
    input  logic [7:0] poly_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] poly_out,
    output logic       div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

    generate
        if (ITER != 7) begin : g_bad_iter
            $error("gf256_poly_div_iterative: ITER must be 7 for GF(2^8)");
        end
    endgenerate

    function automatic logic [7:0] gf_mult(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] prod;
        logic [7:0] sh;
        prod = '0;
        sh   = p;
        for (int unsigned i = 0; i < 8; i++) begin
            if (q[i]) prod = prod ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY) : {sh[6:0], 1'b0};
        end
        return prod;
    endfunction

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] x_q, x_d;
    logic       zflag_q, zflag_d;

    logic [7:0] sq_in;
    logic [7:0] sq_out;
    logic [7:0] acc_mul;
    logic       accept;
    logic       release_out;

    // One squarer serves both the initial b^2 in IDLE and the x^2 update in RUN.
    assign sq_in   = (state_q == S_IDLE) ? poly_b : x_q;
    assign sq_out  = gf_mult(sq_in, sq_in);
    assign acc_mul = gf_mult(acc_q, x_q);

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign poly_out    = out_valid ? acc_q : '0;
    assign div_by_zero = out_valid ? zflag_q : 1'b0;

    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        x_d     = x_q;
        zflag_d = zflag_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = poly_a;
                    x_d     = sq_out;
                    zflag_d = (poly_b == 8'h00);
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef GF256_DIV_FASTPATH_EN
                    if (poly_b == 8'h00) begin
                        acc_d   = '0;
                        state_d = S_DONE;
                    end else if (poly_b == 8'h01) begin
                        state_d = S_DONE;
                    end
`else
`endif
                end
            end
            S_RUN: begin
                acc_d = acc_mul;
                x_d   = sq_out;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (release_out) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            zflag_q <= zflag_d;
        end
    end

endmodule

// File: tb/tb_gf256_poly_div_iterative.sv
// Self-checking bench for gf256_poly_div_iterative: directed cases, backpressure, mid-run reset,
// and a sweep of every nonzero divisor against a carry-less-multiply / exhaustive-search model.
module tb_gf256_poly_div_iterative;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] poly_a;
    logic [7:0] poly_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] poly_out;
    logic       div_by_zero;

    int total  = 0;
    int passed = 0;
    bit hold_valid = 0;

    gf256_poly_div_iterative #(.POLY(8'h1D), .ITER(7)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .poly_a      (poly_a),
        .poly_b      (poly_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .poly_out    (poly_out),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field product: carry-less multiply to 15 bits, then polynomial long division by 0x11D.
    function automatic int ref_mul(input int p, input int q);
        int prod = 0;
        for (int i = 0; i < 8; i++)
            if (((q >> i) & 1) == 1) prod = prod ^ (p << i);
        for (int i = 15; i >= 8; i--)
            if (((prod >> i) & 1) == 1) prod = prod ^ (32'h11D << (i - 8));
        return prod;
    endfunction

    // Quotient by search: the unique q with q*b == a, or 0 when b is 0.
    function automatic int ref_div(input int a, input int b);
        if (b == 0) return 0;
        for (int q = 0; q < 256; q++)
            if (ref_mul(q, b) == a) return q;
        return -1;
    endfunction

    function automatic int exp_lat(input int b);
`ifdef GF256_DIV_FASTPATH_EN
        if (b <= 1) return 0;
`endif
        return 7;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
        int          n;
        int          k;
        bit          ir_bad;
        bit          stab_bad;
        logic [7:0]  snap_out;
        logic        snap_z;
        int          exp_q;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        poly_a    = a;
        poly_b    = b;
        out_ready = (stall == 0);
        tick();
        in_valid = hold_valid;
        poly_a   = ~a;
        poly_b   = ~b;
        k        = 0;
        ir_bad   = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            if (in_ready !== 1'b0) ir_bad = 1;
            tick();
            k++;
        end
        check("out_valid_rise", {31'd0, out_valid}, 32'd1);
        check("latency", k, exp_lat(b));
        check("in_ready_busy", {31'd0, ir_bad}, 32'd0);
        exp_q    = ref_div(a, b);
        snap_out = poly_out;
        snap_z   = div_by_zero;
        stab_bad = 0;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (out_valid !== 1'b1 || poly_out !== snap_out || div_by_zero !== snap_z || in_ready !== 1'b0)
                stab_bad = 1;
        end
        if (stall > 0) check("stall_stable", {31'd0, stab_bad}, 32'd0);
        out_ready = 1'b1;
        check("quotient", {24'd0, poly_out}, exp_q);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, (b == 8'h00)});
        if (b != 8'h00) check("product", ref_mul(poly_out, b), a);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        poly_a    = '0;
        poly_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_poly_out", {24'd0, poly_out}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(8'h01, 8'h02, 0);
        run_op(8'h02, 8'h02, 0);
        run_op(8'h37, 8'h01, 0);
        run_op(8'h00, 8'h5A, 0);
        run_op(8'h9C, 8'h00, 0);
        run_op(8'h01, 8'h03, 0);

        // Backpressure with in_valid held high through RUN/DONE, then an immediate follow-on op.
        hold_valid = 1;
        run_op(8'hC4, 8'h77, 20);
        hold_valid = 0;
        run_op(8'h5B, 8'hE1, 0);

        // Reset pulsed in the middle of RUN.
        in_valid = 1'b1;
        poly_a   = 8'h45;
        poly_b   = 8'h99;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_poly_out", {24'd0, poly_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_idle_valid", {31'd0, out_valid}, 32'd0);
        run_op(8'h01, 8'h02, 0);

        for (int b = 1; b < 256; b++) begin
            hold_valid = ($urandom_range(0, 3) == 0);
            run_op(8'($urandom_range(0, 255)), 8'(b), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
